// File: rtl/fifo_rx_pkg.sv
// Shared constants for the Zigbee receive FIFO: sizes and APB response codes.
package fifo_rx_pkg;

  localparam int   DEFAULT_DEPTH = 64;
  localparam int   ADDR_W        = $clog2(DEFAULT_DEPTH);
  localparam int   BYTE_W        = 8;

  // APB pslverr encoding
  localparam logic APB_OKAY  = 1'b0;
  localparam logic APB_ERROR = 1'b1;

endpackage : fifo_rx_pkg

// File: rtl/bit_deserializer.sv
// Rebuilds bytes LSB-first from the demodulator bit strobe.
// byte_valid/byte_data are combinational on the 8th strobe so the FIFO
// can capture the byte on the same edge that samples its last bit.
module bit_deserializer
  import fifo_rx_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en_rx,
  input  logic              bit_in,
  input  logic              bit_en,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data
);

  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;

  // Next-state: drop the partial byte when receive is disabled, else place the bit
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (!en_rx) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (bit_en) begin
      shift_d[bit_cnt_q] = bit_in;
      bit_cnt_d          = bit_cnt_q + 3'd1;  // wraps 7 -> 0 on byte completion
    end
  end

  assign byte_valid = en_rx & bit_en & (bit_cnt_q == 3'd7);
  // shift_d already holds the incoming 8th bit in position 7
  assign byte_data  = shift_d;

  // Counter and shift register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

endmodule : bit_deserializer

// File: rtl/fifo_rx.sv
// Receive FIFO: deserialized bytes are pushed into a circular buffer and
// drained by the CPU through a zero-wait-state, read-only APB slave port.
module fifo_rx
  import fifo_rx_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en_rx,
  input  logic              bit_in,
  input  logic              bit_en,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  output logic [BYTE_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              mem_state,
  output logic              empty,
  output logic              overflow
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             PW      = AW + 1;  // extra wrap bit tells full from empty
  localparam logic [PW-1:0]  PTR_ONE = PW'(1);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              full, apb_access, apb_read, pop, push;

  bit_deserializer u_deser (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_rx     (en_rx),
    .bit_in    (bit_in),
    .bit_en    (bit_en),
    .byte_valid(byte_valid),
    .byte_data (byte_data)
  );

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign apb_access = psel & penable;
  assign apb_read   = apb_access & ~pwrite;
  assign pop        = apb_read & ~empty;
  // A pop on a full FIFO frees the slot the incoming byte lands in
  assign push       = byte_valid & (~full | pop);

  assign mem_state  = full;
  assign overflow   = overflow_q;
  assign prdata     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // APB response: every access phase completes at once; writes and empty reads error
  always_comb begin
    pready  = apb_access;
    pslverr = APB_OKAY;
    if (apb_access && (pwrite || empty)) begin
      pslverr = APB_ERROR;
    end
  end

  // Pointer advance and sticky overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (!en_rx) begin
      overflow_d = 1'b0;
    end else if (byte_valid && !push) begin
      overflow_d = 1'b1;
    end
  end

  // Pointer and flag state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; contents need no reset since empty masks prdata
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= byte_data;
    end
  end

endmodule : fifo_rx

// File: tb/tb_fifo_rx.sv
// Self-checking bench for fifo_rx against a queue-based byte model.
module tb_fifo_rx;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       reset_n, en_rx, bit_in, bit_en, psel, penable, pwrite;
  logic [7:0] prdata;
  logic       pready, pslverr, mem_state, empty, overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes currently held and the sticky overflow flag
  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;

  always #5 clk = ~clk;

  fifo_rx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .en_rx(en_rx), .bit_in(bit_in), .bit_en(bit_en),
    .psel(psel), .penable(penable), .pwrite(pwrite), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .mem_state(mem_state), .empty(empty),
    .overflow(overflow)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endfunction

  function automatic void model_pop();
    if (model_q.size() > 0) void'(model_q.pop_front());
  endfunction

  task automatic send_bits(input logic [7:0] b, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bit_in = b[i];
      bit_en = 1'b1;
      cycle();
      bit_en = 1'b0;
      bit_in = 1'b0;
      repeat (gap - 1) cycle();
    end
  endtask

  task automatic feed_byte(input logic [7:0] b, input int gap);
    send_bits(b, 8, gap);
    model_push(b);
  endtask

  // Full setup + access APB read; returns what the bus showed in the access phase
  task automatic apb_read(output logic [7:0] d, output logic rdy, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    cycle();
    penable = 1'b1;
    #1;
    d = prdata; rdy = pready; err = pslverr;
    cycle();
    psel = 1'b0; penable = 1'b0;
    model_pop();
  endtask

  task automatic read_and_compare(input string tag);
    logic [7:0] d, exp_d;
    logic r, e, exp_e;
    exp_e = (model_q.size() == 0);
    exp_d = exp_e ? 8'h00 : model_q[0];
    apb_read(d, r, e);
    checks++;
    if (d !== exp_d || r !== 1'b1 || e !== exp_e) begin
      failures++;
      $display("FAIL %s_read got data=%h ready=%b err=%b exp data=%h ready=1 err=%b",
               tag, d, r, e, exp_d, exp_e);
    end
  endtask

  task automatic check_flags(input string tag);
    checks++;
    if (empty !== (model_q.size() == 0) || mem_state !== (model_q.size() == DEPTH) ||
        overflow !== model_ovf) begin
      failures++;
      $display("FAIL %s_flags got empty=%b full=%b ovf=%b exp empty=%b full=%b ovf=%b",
               tag, empty, mem_state, overflow, model_q.size() == 0,
               model_q.size() == DEPTH, model_ovf);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en_rx = 1'b1; bit_in = 1'b0; bit_en = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b1;
    cycle();
    checks++;
    if (prdata !== 8'h00 || pready !== 1'b0 || pslverr !== 1'b0 || mem_state !== 1'b0 ||
        empty !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got prdata=%h rdy=%b err=%b full=%b empty=%b ovf=%b exp 00 0 0 0 1 0",
               prdata, pready, pslverr, mem_state, empty, overflow);
    end
    psel = 1'b1;
    #1;
    checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0) begin
      failures++;
      $display("FAIL setup_phase got rdy=%b err=%b exp rdy=0 err=0", pready, pslverr);
    end
    cycle();
    penable = 1'b1;
    #1;
    checks++;
    if (pready !== 1'b1 || pslverr !== 1'b1 || prdata !== 8'h00) begin
      failures++;
      $display("FAIL empty_read got rdy=%b err=%b data=%h exp rdy=1 err=1 data=00",
               pready, pslverr, prdata);
    end
    cycle();
    psel = 1'b0; penable = 1'b0;
    check_flags("after_empty_read");
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      feed_byte(8'(i), 4);
      check_flags("fill");
    end
    for (int i = 0; i < DEPTH; i++) read_and_compare("drain");
    check_flags("drained");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) feed_byte(8'(i), 1);
    feed_byte(8'hA5, 1);
    check_flags("overflow_set");
    for (int i = 0; i < DEPTH; i++) read_and_compare("ovf_drain");
    check_flags("ovf_drained");
    en_rx = 1'b0;
    cycle();
    en_rx = 1'b1;
    model_ovf = 1'b0;
    check_flags("ovf_cleared");
  endtask

  task automatic test_simultaneous_full();
    logic [7:0] b5a, exp_d, last, d;
    logic r, e;
    b5a = 8'h5A;
    for (int i = 0; i < DEPTH; i++) feed_byte(8'($urandom), $urandom_range(1, 3));
    send_bits(b5a, 7, 1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    cycle();
    penable = 1'b1; bit_in = b5a[7]; bit_en = 1'b1;
    exp_d = model_q[0];
    #1;
    checks++;
    if (prdata !== exp_d || pslverr !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_push got data=%h err=%b exp data=%h err=0", prdata, pslverr, exp_d);
    end
    cycle();
    bit_en = 1'b0; bit_in = 1'b0; psel = 1'b0; penable = 1'b0;
    model_pop();
    model_push(b5a);
    check_flags("full_pop_push");
    for (int i = 0; i < DEPTH - 1; i++) read_and_compare("simul_drain");
    apb_read(last, r, e);
    d = last;
    checks++;
    if (d !== 8'h5A || e !== 1'b0) begin
      failures++;
      $display("FAIL last_is_5a got data=%h err=%b exp data=5a err=0", d, e);
    end
    check_flags("simul_drained");
  endtask

  task automatic test_simultaneous_empty();
    logic [7:0] b;
    b = 8'($urandom);
    send_bits(b, 7, 1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    cycle();
    penable = 1'b1; bit_in = b[7]; bit_en = 1'b1;
    #1;
    checks++;
    if (prdata !== 8'h00 || pslverr !== 1'b1 || pready !== 1'b1) begin
      failures++;
      $display("FAIL empty_pop_push got data=%h err=%b rdy=%b exp data=00 err=1 rdy=1",
               prdata, pslverr, pready);
    end
    cycle();
    bit_en = 1'b0; bit_in = 1'b0; psel = 1'b0; penable = 1'b0;
    model_pop();
    model_push(b);
    check_flags("empty_pop_push");
    read_and_compare("empty_simul");
  endtask

  task automatic test_abort();
    send_bits(8'($urandom), 5, 1);
    en_rx = 1'b0;
    cycle();
    en_rx = 1'b1;
    feed_byte(8'h3C, 2);
    checks++;
    if (empty !== 1'b0 || prdata !== 8'h3C) begin
      failures++;
      $display("FAIL abort_byte got empty=%b data=%h exp empty=0 data=3c", empty, prdata);
    end
    read_and_compare("abort");
    check_flags("abort_done");
  endtask

  task automatic test_write();
    for (int i = 0; i < 3; i++) feed_byte(8'($urandom), 1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    cycle();
    penable = 1'b1;
    #1;
    checks++;
    if (pready !== 1'b1 || pslverr !== 1'b1) begin
      failures++;
      $display("FAIL apb_write got rdy=%b err=%b exp rdy=1 err=1", pready, pslverr);
    end
    cycle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check_flags("after_write");
    for (int i = 0; i < 3; i++) read_and_compare("write_drain");
    check_flags("write_drained");
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 6) feed_byte(8'($urandom), $urandom_range(1, 3));
      else read_and_compare("rand");
      check_flags("rand");
    end
    while (model_q.size() > 0) read_and_compare("rand_drain");
    en_rx = 1'b0;
    cycle();
    en_rx = 1'b1;
    model_ovf = 1'b0;
    check_flags("rand_end");
  endtask

  task automatic test_reset_mid();
    feed_byte(8'h11, 1);
    feed_byte(8'h22, 1);
    send_bits(8'hFF, 4, 1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    cycle();
    penable = 1'b1;
    #2;
    reset_n = 1'b0;
    psel = 1'b0; penable = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    checks++;
    if (prdata !== 8'h00 || pready !== 1'b0 || pslverr !== 1'b0 || mem_state !== 1'b0 ||
        empty !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got prdata=%h rdy=%b err=%b full=%b empty=%b ovf=%b exp 00 0 0 0 1 0",
               prdata, pready, pslverr, mem_state, empty, overflow);
    end
    cycle();
    reset_n = 1'b1;
    cycle();
    feed_byte(8'h81, 1);
    read_and_compare("post_reset");
    check_flags("post_reset");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simultaneous_full();
    test_simultaneous_empty();
    test_abort();
    test_write();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fifo_rx
